multicycle_cpu: RTL and testbench

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/cpu_regfile.sv | 31 +++
 rtl/multicycle_cpu.sv | 133 +++++++++++++
 tb/tb_multicycle_cpu.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and FSM state enums plus instruction field positions for multicycle_cpu
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_LD   = 4'd0,
    OP_ST   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SLT  = 4'd7,
    OP_ADDI = 4'd8,
    OP_NOP  = 4'd9
  } opcode_e;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
  localparam int OPC_W   = 4;
  localparam int IMM_LSB = 0;
  function automatic int rd_lsb(input int rb, input int dw);
    return dw + 0 * rb;
  endfunction
  function automatic int rs2_lsb(input int rb, input int dw);
    return rb + dw;
  endfunction
  function automatic int rs1_lsb(input int rb, input int dw);
    return 2 * rb + dw;
  endfunction
  function automatic int opc_lsb(input int rb, input int dw);
    return 3 * rb + dw;
  endfunction
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: 2^RB x DW register file, r0 hardwired to zero
// Ports: clk, rst (async active-low clear), i_rs1/i_rs2/i_dbg read selects with
// combinational o_rs1/o_rs2/o_dbg data, i_we/i_wa/i_wd synchronous write port.
module cpu_regfile #(
  parameter int DW = 8,
  parameter int RB = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RB-1:0] i_rs1,
  input  logic [RB-1:0] i_rs2,
  input  logic [RB-1:0] i_dbg,
  input  logic          i_we,
  input  logic [RB-1:0] i_wa,
  input  logic [DW-1:0] i_wd,
  output logic [DW-1:0] o_rs1,
  output logic [DW-1:0] o_rs2,
  output logic [DW-1:0] o_dbg
);
  logic [DW-1:0] r_regs [2**RB];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**RB; i++) r_regs[i] <= '0;
    end else if (i_we && i_wa != '0) begin
      r_regs[i_wa] <= i_wd;
    end
  end
  assign o_rs1 = (i_rs1 == '0) ? '0 : r_regs[i_rs1];
  assign o_rs2 = (i_rs2 == '0) ? '0 : r_regs[i_rs2];
  assign o_dbg = (i_dbg == '0) ? '0 : r_regs[i_dbg];
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: IDLE/DECODE/EXEC/MEM/WB multicycle core with register file and data memory
// Ports: clk, rst (async active-low), instr_valid/instr/instr_ready accept handshake,
// instr_done retire pulse, result_valid/result writeback, illegal sticky flag,
// flags {neg,carry,zero}, dbg_sel/dbg_data register peek.
// Optional macro CPU_FLAGS_EN: when defined, ALU ops and ADDI update flags in EXEC;
// otherwise flags reads 3'b000.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int REG_BITS   = 2,
  localparam int INSTR_WIDTH = OPC_W + 3 * REG_BITS + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_ready,
  output logic                   instr_done,
  output logic                   result_valid,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   illegal,
  output logic [2:0]             flags,
  input  logic [REG_BITS-1:0]    dbg_sel,
  output logic [DATA_WIDTH-1:0]  dbg_data
);
  localparam int OPC_LSB = opc_lsb(REG_BITS, DATA_WIDTH);
  localparam int RS1_LSB = rs1_lsb(REG_BITS, DATA_WIDTH);
  localparam int RS2_LSB = rs2_lsb(REG_BITS, DATA_WIDTH);
  localparam int RD_LSB  = rd_lsb(REG_BITS, DATA_WIDTH);
  state_e                  r_state, w_next;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic [DATA_WIDTH-1:0]   r_res;
  logic                    r_illegal;
  logic [DATA_WIDTH-1:0]   r_mem [2**ADDR_BITS];
  opcode_e                 w_op;
  logic [REG_BITS-1:0]     w_rs1a, w_rs2a, w_rda;
  logic [DATA_WIDTH-1:0]   w_imm, w_rs1, w_rs2, w_b, w_alu;
  logic [ADDR_BITS-1:0]    w_addr;
  logic                    w_is_mem, w_is_alu, w_bad_op;
  assign w_op     = opcode_e'(r_instr[OPC_LSB +: OPC_W]);
  assign w_rs1a   = r_instr[RS1_LSB +: REG_BITS];
  assign w_rs2a   = r_instr[RS2_LSB +: REG_BITS];
  assign w_rda    = r_instr[RD_LSB +: REG_BITS];
  assign w_imm    = r_instr[IMM_LSB +: DATA_WIDTH];
  assign w_bad_op = r_instr[OPC_LSB +: OPC_W] > 4'd9;
  assign w_is_mem = w_op == OP_LD || w_op == OP_ST;
  assign w_is_alu = !w_bad_op && w_op >= OP_ADD && w_op <= OP_ADDI;
  assign w_b      = (w_op == OP_ADDI) ? w_imm : w_rs2;
  assign w_addr   = ADDR_BITS'({1'b0, w_rs1} + {1'b0, w_imm});
  assign w_alu = w_op == OP_SUB ? w_rs1 - w_rs2 :
                 w_op == OP_AND ? w_rs1 & w_rs2 :
                 w_op == OP_OR  ? w_rs1 | w_rs2 :
                 w_op == OP_XOR ? w_rs1 ^ w_rs2 :
                 w_op == OP_SLT ? DATA_WIDTH'(w_rs1 < w_rs2) :
                 w_rs1 + w_b;
  cpu_regfile #(.DW(DATA_WIDTH), .RB(REG_BITS)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_rs1 (w_rs1a),
    .i_rs2 (w_rs2a),
    .i_dbg (dbg_sel),
    .i_we  (result_valid),
    .i_wa  (w_rda),
    .i_wd  (r_res),
    .o_rs1 (w_rs1),
    .o_rs2 (w_rs2),
    .o_dbg (dbg_data)
  );
  always_comb begin
    w_next       = r_state;
    instr_ready  = 1'b0;
    instr_done   = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        w_next      = instr_valid ? S_DECODE : S_IDLE;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_next     = w_is_mem ? S_MEM : w_is_alu ? S_WB : S_IDLE;
        instr_done = !w_is_mem && !w_is_alu;
      end
      S_MEM: begin
        w_next     = (w_op == OP_LD) ? S_WB : S_IDLE;
        instr_done = w_op != OP_LD;
      end
      S_WB: begin
        w_next       = S_IDLE;
        instr_done   = 1'b1;
        result_valid = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_res     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (instr_ready && instr_valid) r_instr <= instr;
      if (r_state == S_EXEC && w_is_alu) r_res <= w_alu;
      if (r_state == S_MEM && w_op == OP_LD) r_res <= r_mem[w_addr];
      if (r_state == S_EXEC && w_bad_op) r_illegal <= 1'b1;
    end
  end
  // Memory is deliberately outside the reset domain so its contents survive rst.
  always_ff @(posedge clk) begin
    if (r_state == S_MEM && w_op == OP_ST) r_mem[w_addr] <= w_rs2;
  end
  assign result  = r_res;
  assign illegal = r_illegal;
`ifdef CPU_FLAGS_EN
  logic [2:0] r_flags;
  logic       w_carry;
  // ADD/ADDI report carry-out, SUB reports borrow, logic ops and SLT clear it.
  assign w_carry = (w_op == OP_ADD || w_op == OP_ADDI) ?
                   1'(({1'b0, w_rs1} + {1'b0, w_b}) >> DATA_WIDTH) :
                   (w_op == OP_SUB) ? (w_rs1 < w_rs2) : 1'b0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_flags <= '0;
    else if (r_state == S_EXEC && w_is_alu) r_flags <= {w_alu[DATA_WIDTH-1], w_carry, w_alu == '0};
  end
  assign flags = r_flags;
`else
  assign flags = 3'b000;
`endif
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed self-checking bench for multicycle_cpu
module tb_multicycle_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [17:0] instr = '0;
  logic [1:0]  dbg_sel = '0;
  logic        instr_ready, instr_done, result_valid, illegal;
  logic [7:0]  result, dbg_data;
  logic [2:0]  flags;
  int          errors = 0;
  int          checks = 0;
  int          lat, busy;
  logic        rv;
  logic [7:0]  res;
  always #5 clk = ~clk;
  multicycle_cpu dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .instr_done   (instr_done),
    .result_valid (result_valid),
    .result       (result),
    .illegal      (illegal),
    .flags        (flags),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );
  function automatic logic [17:0] enc(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] d, input logic [7:0] imm);
    return {op, a, b, d, imm};
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic dbg(input logic [1:0] s, input logic [7:0] exp, input string tag);
    dbg_sel = s;
    #1;
    chk(tag, {8'h00, dbg_data}, {8'h00, exp});
  endtask
  // Offers ins at a negedge, then scrambles instr each cycle to prove it was latched.
  // Returns at the negedge after retirement (core back in IDLE).
  task automatic run(input logic [17:0] ins, input bit hold, output int l, output logic v,
                     output logic [7:0] r, output int b);
    int g = 0;
    l = 0; v = 1'b0; r = 8'h00; b = 0;
    while (!instr_ready && g < 20) begin @(negedge clk); g++; end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (!hold) instr_valid = 1'b0;
      instr = ~ins;
      if (instr_ready) b++;
      if (instr_done) begin l = n; v = result_valid; r = result; break; end
    end
    instr_valid = 1'b0;
    @(negedge clk);
  endtask
  logic [17:0] vins [6];
  logic [7:0]  vexp [6];
  int          extra;
  initial begin
    vins[0] = enc(4'd3, 2'd2, 2'd1, 2'd3, 8'h00); vexp[0] = 8'h02;
    vins[1] = enc(4'd4, 2'd1, 2'd2, 2'd3, 8'h00); vexp[1] = 8'h01;
    vins[2] = enc(4'd5, 2'd1, 2'd2, 2'd3, 8'h00); vexp[2] = 8'hFF;
    vins[3] = enc(4'd6, 2'd1, 2'd2, 2'd3, 8'h00); vexp[3] = 8'hFE;
    vins[4] = enc(4'd7, 2'd2, 2'd1, 2'd3, 8'h00); vexp[4] = 8'h01;
    vins[5] = enc(4'd7, 2'd1, 2'd2, 2'd3, 8'h00); vexp[5] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_done", instr_done, 1'b0);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_flags", flags, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    run(enc(4'd8, 2'd0, 2'd0, 2'd1, 8'h05), 0, lat, rv, res, busy);
    chk("addi_lat", lat, 3);
    chk("addi_rv", rv, 1'b1);
    chk("addi_res", res, 8'h05);
    dbg(2'd1, 8'h05, "addi_r1");
    run(enc(4'd8, 2'd0, 2'd0, 2'd1, 8'hFF), 0, lat, rv, res, busy);
    run(enc(4'd8, 2'd0, 2'd0, 2'd2, 8'h01), 0, lat, rv, res, busy);
    run(enc(4'd2, 2'd1, 2'd2, 2'd3, 8'h00), 0, lat, rv, res, busy);
    chk("add_lat", lat, 3);
    chk("add_res", res, 8'h00);
`ifdef CPU_FLAGS_EN
    chk("add_flags", flags, 3'b011);
`else
    chk("add_flags", flags, 3'b000);
`endif
    dbg(2'd3, 8'h00, "add_r3");
    for (int i = 0; i < 6; i++) begin
      run(vins[i], 0, lat, rv, res, busy);
      chk($sformatf("alu%0d_res", i), res, vexp[i]);
      dbg(2'd3, vexp[i], $sformatf("alu%0d_r3", i));
`ifdef CPU_FLAGS_EN
      if (i == 0) chk("sub_flags", flags, 3'b010);
`endif
    end
    run(enc(4'd9, 2'd1, 2'd2, 2'd3, 8'h00), 0, lat, rv, res, busy);
    chk("nop_lat", lat, 2);
    chk("nop_rv", rv, 1'b0);
    dbg(2'd3, 8'h00, "nop_r3");
    run(enc(4'd1, 2'd0, 2'd2, 2'd0, 8'h1F), 0, lat, rv, res, busy);
    chk("st_lat", lat, 3);
    chk("st_rv", rv, 1'b0);
    run(enc(4'd0, 2'd1, 2'd0, 2'd3, 8'h20), 0, lat, rv, res, busy);
    chk("ld_lat", lat, 4);
    chk("ld_res", res, 8'h01);
    dbg(2'd3, 8'h01, "ld_r3");
    chk("pre_illegal", illegal, 1'b0);
    run(enc(4'hC, 2'd1, 2'd2, 2'd3, 8'h00), 0, lat, rv, res, busy);
    chk("ill_lat", lat, 2);
    chk("ill_rv", rv, 1'b0);
    chk("ill_flag", illegal, 1'b1);
    dbg(2'd3, 8'h01, "ill_r3");
    run(enc(4'd2, 2'd1, 2'd2, 2'd3, 8'h00), 0, lat, rv, res, busy);
    chk("post_ill_res", res, 8'h00);
    chk("post_ill_flag", illegal, 1'b1);
    dbg(2'd3, 8'h00, "post_ill_r3");
    run(enc(4'd8, 2'd0, 2'd0, 2'd0, 8'h07), 1, lat, rv, res, busy);
    chk("hold_lat", lat, 3);
    chk("hold_rv", rv, 1'b1);
    chk("hold_res", res, 8'h07);
    chk("hold_busy_ready", busy, 0);
    dbg(2'd0, 8'h00, "hold_r0");
    extra = 0;
    repeat (4) begin @(negedge clk); if (instr_done) extra++; end
    chk("hold_extra_done", extra, 0);
    chk("hold_ready", instr_ready, 1'b1);
    instr = enc(4'd2, 2'd2, 2'd2, 2'd1, 8'h00);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (5) begin @(negedge clk); if (result_valid || instr_done) extra++; end
    chk("rstmid_pulses", extra, 0);
    chk("rstmid_ready", instr_ready, 1'b1);
    chk("rstmid_result", result, 8'h00);
    dbg(2'd1, 8'h00, "rstmid_r1");
    run(enc(4'd0, 2'd0, 2'd0, 2'd3, 8'h1F), 0, lat, rv, res, busy);
    chk("mem_kept", res, 8'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
